bm_sad_sched: RTL and testbench

- Per-frame scheduler for the block-matching SAD engine.
- Outer loop: disparity phases, 32 disparities each. Inner loop: image rows.
- For each row step, the block fetches the left/right row pair into the input buffer, picks the SAD op (add new row / subtract old row / add and emit SAD line), handshakes one line pass, then advances.
- Sits between the frame controller (start/done) and the SAD engine plus row fetcher.

---
 rtl/bm_sad_sched.sv | 199 +++++++++++++++++++
 tb/tb_bm_sad_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bm_sad_sched.sv
// rtl/bm_sad_sched.sv - per-frame row/disparity scheduler for the block-matching SAD engine
// Optional watchdog on FETCH/WAIT: define BM_SCHED_TMO_EN.
module bm_sad_sched #(
    parameter int PARALLEL = 32,
    parameter int TMO_CYC  = 4096
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       start,
    input  logic [9:0] hgt,
    input  logic [8:0] ndisp,
    input  logic [3:0] hwsz,
    output logic       row_req,
    output logic [9:0] row_idx,
    input  logic       row_ack,
    output logic       enb,
    output logic       lr_rdy,
    output logic       sad_rdy,
    output logic       first_line,
    output logic [3:0] dphase,
    output logic [1:0] op_type,
    input  logic       lr_done,
    output logic [9:0] out_row,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_FIN
    } state_t;

    state_t state, state_nx;

    logic [9:0] hgt_q;
    logic [8:0] ndisp_q;
    logic [3:0] hwsz_q;
    logic [9:0] r_q, r_nx;
    logic       sub_q, sub_nx;
    logic [3:0] dph_q, dph_nx;
    logic       enb_q, err_q, fl_q;
    logic [1:0] op_q;
    logic [9:0] row_q, orow_q;
    logic [3:0] dphase_q;

    logic [9:0] wh;
    logic [8:0] nph;
    logic       cfg_bad, last_step, tmo_hit, load;
    logic [9:0] ld_r;
    logic       ld_sub;
    logic [3:0] ld_dph;
    logic [1:0] dec_op;
    logic [9:0] dec_row;

    if (TMO_CYC <= 0) begin : g_tmo_range
        $error("TMO_CYC must be positive");
    end

    assign wh        = {5'd0, hwsz_q, 1'b1};
    assign nph       = ndisp_q / 9'(PARALLEL);
    assign cfg_bad   = (nph == 9'd0) || (hgt_q < wh);

    // Row/subflag/phase advance applied on leaving NEXT
    always_comb begin
        r_nx   = r_q;
        sub_nx = 1'b0;
        dph_nx = dph_q;
        if (r_q >= wh && !sub_q) begin
            sub_nx = 1'b1;
        end else if (r_q + 10'd1 == hgt_q) begin
            r_nx   = '0;
            dph_nx = dph_q + 4'd1;
        end else begin
            r_nx = r_q + 10'd1;
        end
    end

    assign last_step = ({5'd0, dph_nx} == nph);

`ifdef BM_SCHED_TMO_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (srst || state_nx != state) begin
            tmo_cnt <= '0;
        end else if (state == S_FETCH || state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state == S_FETCH || state == S_WAIT) && (tmo_cnt == 16'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CHK;
            S_CHK:   state_nx = cfg_bad ? S_FIN : S_FETCH;
            S_FETCH: if (row_ack) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (lr_done) state_nx = S_NEXT;
            S_NEXT:  state_nx = last_step ? S_FIN : S_FETCH;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (tmo_hit) state_nx = S_FIN;
    end

    // Op decode for the step about to be fetched (fresh frame or post-advance)
    assign load   = (state == S_CHK || state == S_NEXT) && state_nx == S_FETCH;
    assign ld_r   = (state == S_CHK) ? 10'd0 : r_nx;
    assign ld_sub = (state == S_CHK) ? 1'b0 : sub_nx;
    assign ld_dph = (state == S_CHK) ? 4'd0 : dph_nx;

    always_comb begin
        dec_op  = 2'd0;
        dec_row = ld_r;
        if (ld_r < wh - 10'd1) begin
            dec_op = 2'd0;
        end else if (ld_r == wh - 10'd1) begin
            dec_op = 2'd2;
        end else if (!ld_sub) begin
            dec_op  = 2'd1;
            dec_row = ld_r - wh;
        end else begin
            dec_op = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            hgt_q    <= '0;
            ndisp_q  <= '0;
            hwsz_q   <= '0;
            r_q      <= '0;
            sub_q    <= 1'b0;
            dph_q    <= '0;
            enb_q    <= 1'b0;
            err_q    <= 1'b0;
            fl_q     <= 1'b0;
            op_q     <= '0;
            row_q    <= '0;
            orow_q   <= '0;
            dphase_q <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                hgt_q   <= hgt;
                ndisp_q <= ndisp;
                hwsz_q  <= hwsz;
                err_q   <= 1'b0;
            end
            if (state == S_CHK) begin
                r_q   <= '0;
                sub_q <= 1'b0;
                dph_q <= '0;
                if (cfg_bad) err_q <= 1'b1;
                else         enb_q <= 1'b1;
            end
            if (state == S_NEXT) begin
                r_q   <= r_nx;
                sub_q <= sub_nx;
                dph_q <= dph_nx;
            end
            if (state == S_FIN) enb_q <= 1'b0;
            if (tmo_hit) err_q <= 1'b1;
            if (load) begin
                op_q     <= dec_op;
                row_q    <= dec_row;
                fl_q     <= (ld_r == 10'd0);
                dphase_q <= ld_dph;
                if (dec_op == 2'd2) orow_q <= dec_row - {6'd0, hwsz_q};
            end
        end
    end

    assign row_req    = (state == S_FETCH);
    assign lr_rdy     = (state == S_ISSUE);
    assign done       = (state == S_FIN);
    assign busy       = (state != S_IDLE);
    assign enb        = enb_q;
    assign err        = err_q;
    assign sad_rdy    = 1'b0;
    assign first_line = fl_q;
    assign op_type    = op_q;
    assign row_idx    = row_q;
    assign out_row    = orow_q;
    assign dphase     = dphase_q;

endmodule

// File: tb/tb_bm_sad_sched.sv
// tb/tb_bm_sad_sched.sv - directed self-checking bench for bm_sad_sched
module tb_bm_sad_sched;

    logic       clk = 1'b0;
    logic       srst, start;
    logic [9:0] hgt;
    logic [8:0] ndisp;
    logic [3:0] hwsz;
    logic       row_req;
    logic [9:0] row_idx;
    logic       row_ack;
    logic       enb, lr_rdy, sad_rdy, first_line;
    logic [3:0] dphase;
    logic [1:0] op_type;
    logic       lr_done;
    logic [9:0] out_row;
    logic       busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0, lr_rdy_seen = 0, req_seen = 0;
    int log_op[64], log_row[64], log_fl[64], log_dph[64], log_orow[64];

    int exp1_op[13]  = '{0, 0, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
    int exp1_row[13] = '{0, 1, 2, 0, 3, 1, 4, 2, 5, 3, 6, 4, 7};
    int exp1_orow[6] = '{1, 2, 3, 4, 5, 6};
    int exp2_op[7]   = '{2, 1, 2, 1, 2, 1, 2};
    int exp2_row[7]  = '{0, 0, 1, 1, 2, 2, 3};
    int exp2_orow[4] = '{0, 1, 2, 3};

    always #5 clk = ~clk;

    bm_sad_sched #(.PARALLEL(32), .TMO_CYC(100)) dut (
        .clk(clk), .srst(srst), .start(start), .hgt(hgt), .ndisp(ndisp), .hwsz(hwsz),
        .row_req(row_req), .row_idx(row_idx), .row_ack(row_ack), .enb(enb),
        .lr_rdy(lr_rdy), .sad_rdy(sad_rdy), .first_line(first_line), .dphase(dphase),
        .op_type(op_type), .lr_done(lr_done), .out_row(out_row), .busy(busy),
        .done(done), .err(err)
    );

    always @(negedge clk) begin
        if (done)    done_seen++;
        if (lr_rdy)  lr_rdy_seen++;
        if (row_req) req_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Called with start already driven high at a negedge
    task automatic run_frame(input bit spur, output int npass, output int ndone);
        npass = 0;
        ndone = 0;
        tick;
        start = 1'b0;
        check("chk_busy", busy, 1);
        check("chk_req", row_req, 0);
        tick;
        for (int g = 0; g < 64; g++) begin
            if (done) begin
                ndone++;
                break;
            end
            check("req", row_req, 1);
            check("enb", enb, 1);
            log_op[npass]   = int'(op_type);
            log_row[npass]  = int'(row_idx);
            log_fl[npass]   = int'(first_line);
            log_dph[npass]  = int'(dphase);
            log_orow[npass] = int'(out_row);
            if (spur) lr_done = 1'b1;
            tick; lr_done = 1'b0;
            tick;
            tick;
            tick; row_ack = 1'b1;
            tick; row_ack = 1'b0;
            check("lr_rdy_hi", lr_rdy, 1);
            tick;
            check("lr_rdy_lo", lr_rdy, 0);
            if (spur) row_ack = 1'b1;
            tick; row_ack = 1'b0;
            tick; lr_done = 1'b1;
            check("op_hold", op_type, log_op[npass]);
            check("row_hold", row_idx, log_row[npass]);
            tick; lr_done = 1'b0;
            check("next_req", row_req, 0);
            tick;
            npass++;
        end
    endtask

    initial begin
        int np, nd, k, c0, r0;
        srst = 1'b1; start = 1'b0; row_ack = 1'b0; lr_done = 1'b0;
        hgt = '0; ndisp = '0; hwsz = '0;
        repeat (3) tick;
        srst = 1'b0;
        tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_enb", enb, 0);
        check("rst_req", row_req, 0);
        check("rst_lr_rdy", lr_rdy, 0);
        check("rst_err", err, 0);
        check("rst_outs", {sad_rdy, first_line, dphase, op_type, row_idx, out_row}, 0);

        // hgt=8, hwsz=1, two phases
        hgt = 10'd8; hwsz = 4'd1; ndisp = 9'd64;
        c0 = lr_rdy_seen;
        start = 1'b1;
        run_frame(1'b0, np, nd);
        check("f1_npass", np, 26);
        check("f1_done", nd, 1);
        check("f1_err", err, 0);
        k = 0;
        for (int i = 0; i < 26; i++) begin
            check("f1_op", log_op[i], exp1_op[i % 13]);
            check("f1_row", log_row[i], exp1_row[i % 13]);
            check("f1_fl", log_fl[i], (i % 13 == 0) ? 1 : 0);
            check("f1_dph", log_dph[i], i / 13);
            if (exp1_op[i % 13] == 2) begin
                check("f1_orow", log_orow[i], exp1_orow[k % 6]);
                k++;
            end
        end
        tick;
        check("f1_idle_busy", busy, 0);
        check("f1_idle_enb", enb, 0);
        check("f1_lr_rdy_cnt", lr_rdy_seen - c0, 26);

        // Bad config: hgt < WH, second start during CHK ignored
        hgt = 10'd2; hwsz = 4'd1; ndisp = 9'd64;
        r0 = req_seen;
        start = 1'b1;
        tick; start = 1'b0;
        check("e_busy", busy, 1);
        check("e_nodone", done, 0);
        start = 1'b1;
        tick; start = 1'b0;
        check("e_done", done, 1);
        check("e_err", err, 1);
        check("e_req", row_req, 0);
        tick;
        check("e_idle", busy, 0);
        check("e_sticky", err, 1);
        tick;
        check("e_ignored", busy, 0);
        check("e_no_fetch", req_seen - r0, 0);

        // srst during WAIT
        hgt = 10'd8; hwsz = 4'd1; ndisp = 9'd64;
        start = 1'b1;
        tick; start = 1'b0;
        tick;
        tick; tick; tick; row_ack = 1'b1;
        tick; row_ack = 1'b0;
        check("s_issue", lr_rdy, 1);
        tick;
        check("s_wait_fl", first_line, 1);
        c0 = done_seen;
        srst = 1'b1;
        tick; srst = 1'b0;
        check("s_busy", busy, 0);
        check("s_enb", enb, 0);
        check("s_err", err, 0);
        check("s_outs", {row_req, lr_rdy, done, first_line, dphase, op_type, row_idx, out_row}, 0);
        tick; tick;
        check("s_no_done", done_seen - c0, 0);

        // Simultaneous start and srst
        srst = 1'b1; start = 1'b1;
        tick; srst = 1'b0; start = 1'b0;
        check("ss_busy0", busy, 0);
        tick;
        check("ss_busy1", busy, 0);

        // hwsz=0, hgt=4, one phase, spurious handshakes
        hgt = 10'd4; hwsz = 4'd0; ndisp = 9'd32;
        c0 = lr_rdy_seen;
        start = 1'b1;
        run_frame(1'b1, np, nd);
        check("f2_npass", np, 7);
        check("f2_done", nd, 1);
        check("f2_err", err, 0);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            check("f2_op", log_op[i], exp2_op[i]);
            check("f2_row", log_row[i], exp2_row[i]);
            check("f2_fl", log_fl[i], (i == 0) ? 1 : 0);
            check("f2_dph", log_dph[i], 0);
            if (exp2_op[i] == 2) begin
                check("f2_orow", log_orow[i], exp2_orow[k]);
                k++;
            end
        end
        tick;
        check("f2_lr_rdy_cnt", lr_rdy_seen - c0, 7);

        // lr_done never arrives
        hgt = 10'd4; hwsz = 4'd0; ndisp = 9'd32;
        start = 1'b1;
        tick; start = 1'b0;
        tick;
        tick; tick; tick; row_ack = 1'b1;
        tick; row_ack = 1'b0;
        tick;
        c0 = done_seen;
`ifdef BM_SCHED_TMO_EN
        repeat (99) tick;
        check("t_early", done, 0);
        tick;
        check("t_done", done, 1);
        check("t_err", err, 1);
        tick;
        check("t_idle", busy, 0);
`else
        repeat (150) tick;
        check("t_busy", busy, 1);
        check("t_no_done", done_seen - c0, 0);
        srst = 1'b1;
        tick; srst = 1'b0;
        check("t_rst", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
